// File: rtl/acc_cu_pkg.sv
// Shared types and encodings for the accumulator control unit: sequencer states,
// instruction classes and the select codes driven onto the datapath.
package acc_cu_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH   = 2'b00,
        ST_DECODE  = 2'b01,
        ST_EXECUTE = 2'b10,
        ST_HALT    = 2'b11
    } state_e;

    // Instruction class lives in instr[7:5]; the operand (address or immediate) below it.
    localparam logic [2:0] CLS_LDA  = 3'b000;
    localparam logic [2:0] CLS_STA  = 3'b001;
    localparam logic [2:0] CLS_ADD  = 3'b010;
    localparam logic [2:0] CLS_SUB  = 3'b011;
    localparam logic [2:0] CLS_JMP  = 3'b100;
    localparam logic [2:0] CLS_JZ   = 3'b101;
    localparam logic [2:0] CLS_IMM  = 3'b110;
    localparam logic [2:0] CLS_MISC = 3'b111;

    localparam logic [7:0] OP_NOT = 8'hE0;
    localparam logic [7:0] OP_CLR = 8'hE1;
    localparam logic [7:0] OP_HLT = 8'hFF;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_NOT = 4'b0101;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_JUMP = 2'b01;

    localparam logic [1:0] ACC_ALU  = 2'b00;
    localparam logic [1:0] ACC_MEM  = 2'b01;
    localparam logic [1:0] ACC_ZERO = 2'b10;

    localparam logic [1:0] ADDR_PC    = 2'b00;
    localparam logic [1:0] ADDR_INSTR = 2'b01;

    localparam logic B_MEM = 1'b0;
    localparam logic B_IMM = 1'b1;

    // Classes whose operand is a data-memory address that must be presented from DECODE on.
    function automatic logic is_mem_operand(input logic [7:0] instr);
        return (instr[7:5] == CLS_LDA) || (instr[7:5] == CLS_STA) ||
               (instr[7:5] == CLS_ADD) || (instr[7:5] == CLS_SUB);
    endfunction

endpackage

// File: rtl/acc_cu_decoder.sv
// Combinational map from sequencer state, IR byte and ZF to raw datapath controls.
// ACC_CU_TRAP_ILLEGAL_EN: undefined encodings request HALT instead of executing as NOP.
module acc_cu_decoder
    import acc_cu_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [7:0]         instr,
    input  logic               zf,
    output logic               pc_write_enable,
    output logic [1:0]         pc_mux_select,
    output logic               acc_write_enable,
    output logic [1:0]         acc_mux_select,
    output logic               ir_load_enable,
    output logic [3:0]         alu_opcode,
    output logic               alu_inputb_mux_select,
    output logic               memory_write_enable,
    output logic [1:0]         memory_address_mux_select,
    output logic               halt_req
);

    always_comb begin
        pc_write_enable           = 1'b0;
        pc_mux_select             = PC_INC;
        acc_write_enable          = 1'b0;
        acc_mux_select            = ACC_ALU;
        ir_load_enable            = 1'b0;
        alu_opcode                = ALU_NOP;
        alu_inputb_mux_select     = B_MEM;
        memory_write_enable       = 1'b0;
        memory_address_mux_select = ADDR_PC;
        halt_req                  = 1'b0;

        case (state_e'(state))
            ST_FETCH: begin
                memory_address_mux_select = ADDR_PC;
                ir_load_enable            = 1'b1;
                pc_write_enable           = 1'b1;
                pc_mux_select             = PC_INC;
            end
            ST_DECODE: begin
                if (is_mem_operand(instr)) begin
                    memory_address_mux_select = ADDR_INSTR;
                end
            end
            ST_EXECUTE: begin
                case (instr[7:5])
                    CLS_LDA: begin
                        memory_address_mux_select = ADDR_INSTR;
                        acc_write_enable          = 1'b1;
                        acc_mux_select            = ACC_MEM;
                    end
                    CLS_STA: begin
                        memory_address_mux_select = ADDR_INSTR;
                        memory_write_enable       = 1'b1;
                    end
                    CLS_ADD: begin
                        memory_address_mux_select = ADDR_INSTR;
                        acc_write_enable          = 1'b1;
                        acc_mux_select            = ACC_ALU;
                        alu_opcode                = ALU_ADD;
                        alu_inputb_mux_select     = B_MEM;
                    end
                    CLS_SUB: begin
                        memory_address_mux_select = ADDR_INSTR;
                        acc_write_enable          = 1'b1;
                        acc_mux_select            = ACC_ALU;
                        alu_opcode                = ALU_SUB;
                        alu_inputb_mux_select     = B_MEM;
                    end
                    CLS_JMP: begin
                        pc_write_enable = 1'b1;
                        pc_mux_select   = PC_JUMP;
                    end
                    CLS_JZ: begin
                        if (zf) begin
                            pc_write_enable = 1'b1;
                            pc_mux_select   = PC_JUMP;
                        end
                    end
                    CLS_IMM: begin
                        acc_write_enable      = 1'b1;
                        acc_mux_select        = ACC_ALU;
                        alu_inputb_mux_select = B_IMM;
                        alu_opcode            = instr[4] ? ALU_SUB : ALU_ADD;
                    end
                    CLS_MISC: begin
                        case (instr)
                            OP_NOT: begin
                                acc_write_enable = 1'b1;
                                acc_mux_select   = ACC_ALU;
                                alu_opcode       = ALU_NOT;
                            end
                            OP_CLR: begin
                                acc_write_enable = 1'b1;
                                acc_mux_select   = ACC_ZERO;
                            end
                            OP_HLT: begin
                                halt_req = 1'b1;
                            end
                            default: begin
`ifdef ACC_CU_TRAP_ILLEGAL_EN
                                halt_req = 1'b1;
`endif
                            end
                        endcase
                    end
                endcase
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/accumulator_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer for the 8-bit accumulator machine; the
// 2-bit state register doubles as a scan segment. Optional macro: ACC_CU_TRAP_ILLEGAL_EN.
module accumulator_control_unit
    import acc_cu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       proc_en,
    input  logic       scan_enable,
    input  logic       scan_in,
    output logic       scan_out,
    input  logic [7:0] instr,
    input  logic       ZF,
    output logic       PC_write_enable,
    output logic [1:0] PC_mux_select,
    output logic       ACC_write_enable,
    output logic [1:0] ACC_mux_select,
    output logic       IR_load_enable,
    output logic [3:0] ALU_opcode,
    output logic       ALU_inputB_mux_select,
    output logic       Memory_write_enable,
    output logic [1:0] Memory_address_mux_select,
    output logic       halt
);

    state_e     state_q;
    state_e     state_d;
    logic       run_ok;

    logic       dec_pc_write_enable;
    logic [1:0] dec_pc_mux_select;
    logic       dec_acc_write_enable;
    logic [1:0] dec_acc_mux_select;
    logic       dec_ir_load_enable;
    logic [3:0] dec_alu_opcode;
    logic       dec_alu_inputb_mux_select;
    logic       dec_memory_write_enable;
    logic [1:0] dec_memory_address_mux_select;
    logic       dec_halt_req;

    acc_cu_decoder u_decoder (
        .state                     (state_q),
        .instr                     (instr),
        .zf                        (ZF),
        .pc_write_enable           (dec_pc_write_enable),
        .pc_mux_select             (dec_pc_mux_select),
        .acc_write_enable          (dec_acc_write_enable),
        .acc_mux_select            (dec_acc_mux_select),
        .ir_load_enable            (dec_ir_load_enable),
        .alu_opcode                (dec_alu_opcode),
        .alu_inputb_mux_select     (dec_alu_inputb_mux_select),
        .memory_write_enable       (dec_memory_write_enable),
        .memory_address_mux_select (dec_memory_address_mux_select),
        .halt_req                  (dec_halt_req)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan shift takes priority over sequencing; every shifted-in code is a legal state.
    always_comb begin
        state_d = state_q;
        if (scan_enable) begin
            state_d = state_e'({scan_in, state_q[1]});
        end else if (proc_en) begin
            case (state_q)
                ST_FETCH:   state_d = ST_DECODE;
                ST_DECODE:  state_d = ST_EXECUTE;
                ST_EXECUTE: state_d = dec_halt_req ? ST_HALT : ST_FETCH;
                ST_HALT:    state_d = ST_HALT;
                default:    state_d = ST_FETCH;
            endcase
        end
    end

    // Reset is included in the gate so enables fall with rst, not at the next edge.
    assign run_ok = rst && !scan_enable && proc_en;

    always_comb begin
        PC_write_enable           = 1'b0;
        PC_mux_select             = PC_INC;
        ACC_write_enable          = 1'b0;
        ACC_mux_select            = ACC_ALU;
        IR_load_enable            = 1'b0;
        ALU_opcode                = ALU_NOP;
        ALU_inputB_mux_select     = B_MEM;
        Memory_write_enable       = 1'b0;
        Memory_address_mux_select = ADDR_PC;
        if (run_ok) begin
            PC_write_enable           = dec_pc_write_enable;
            PC_mux_select             = dec_pc_mux_select;
            ACC_write_enable          = dec_acc_write_enable;
            ACC_mux_select            = dec_acc_mux_select;
            IR_load_enable            = dec_ir_load_enable;
            ALU_opcode                = dec_alu_opcode;
            ALU_inputB_mux_select     = dec_alu_inputb_mux_select;
            Memory_write_enable       = dec_memory_write_enable;
            Memory_address_mux_select = dec_memory_address_mux_select;
        end
    end

    assign halt     = (state_q == ST_HALT);
    assign scan_out = state_q[0];

endmodule

// File: tb/tb_accumulator_control_unit.sv
// Directed-vector bench for accumulator_control_unit; every expected control word is hand-derived.
module tb_accumulator_control_unit;

    logic       clk;
    logic       rst;
    logic       proc_en;
    logic       scan_enable;
    logic       scan_in;
    logic       scan_out;
    logic [7:0] instr;
    logic       ZF;
    logic       PC_write_enable;
    logic [1:0] PC_mux_select;
    logic       ACC_write_enable;
    logic [1:0] ACC_mux_select;
    logic       IR_load_enable;
    logic [3:0] ALU_opcode;
    logic       ALU_inputB_mux_select;
    logic       Memory_write_enable;
    logic [1:0] Memory_address_mux_select;
    logic       halt;

    logic [15:0] ctrl;
    int          errors;
    int          checks;

    accumulator_control_unit dut (
        .clk                       (clk),
        .rst                       (rst),
        .proc_en                   (proc_en),
        .scan_enable               (scan_enable),
        .scan_in                   (scan_in),
        .scan_out                  (scan_out),
        .instr                     (instr),
        .ZF                        (ZF),
        .PC_write_enable           (PC_write_enable),
        .PC_mux_select             (PC_mux_select),
        .ACC_write_enable          (ACC_write_enable),
        .ACC_mux_select            (ACC_mux_select),
        .IR_load_enable            (IR_load_enable),
        .ALU_opcode                (ALU_opcode),
        .ALU_inputB_mux_select     (ALU_inputB_mux_select),
        .Memory_write_enable       (Memory_write_enable),
        .Memory_address_mux_select (Memory_address_mux_select),
        .halt                      (halt)
    );

    assign ctrl = {PC_write_enable, PC_mux_select, ACC_write_enable, ACC_mux_select,
                   IR_load_enable, ALU_opcode, ALU_inputB_mux_select, Memory_write_enable,
                   Memory_address_mux_select, halt};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mk(input logic pcwe, input logic [1:0] pcmux,
                                       input logic accwe, input logic [1:0] accmux,
                                       input logic ir, input logic [3:0] alu, input logic bmux,
                                       input logic memwe, input logic [1:0] amux,
                                       input logic hlt);
        return {pcwe, pcmux, accwe, accmux, ir, alu, bmux, memwe, amux, hlt};
    endfunction

    localparam logic [3:0] NOP = 4'b1111;

    logic [15:0] ctrlOff;
    logic [15:0] ctrlFetch;
    logic [15:0] ctrlDecMem;
    logic [15:0] ctrlHalt;
    logic [1:0]  illegalNext;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic z);
        instr = op;
        ZF    = z;
        #1;
    endtask

    // One full instruction from FETCH: check each phase, then the state it lands in.
    task automatic runInstr(input string tag, input logic [7:0] op, input logic z,
                            input logic [15:0] expDec, input logic [15:0] expExec,
                            input logic [1:0] expNext);
        applyStimulus(op, z);
        checkOutput({tag, "_fetch"}, ctrl, ctrlFetch);
        tick(); #1;
        checkOutput({tag, "_decode"}, ctrl, expDec);
        tick(); #1;
        checkOutput({tag, "_exec"}, ctrl, expExec);
        tick(); #1;
        checkOutput({tag, "_next"}, 16'(dut.state_q), 16'(expNext));
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        ctrlOff     = mk(0, 2'b00, 0, 2'b00, 0, NOP, 0, 0, 2'b00, 0);
        ctrlFetch   = mk(1, 2'b00, 0, 2'b00, 1, NOP, 0, 0, 2'b00, 0);
        ctrlDecMem  = mk(0, 2'b00, 0, 2'b00, 0, NOP, 0, 0, 2'b01, 0);
        ctrlHalt    = mk(0, 2'b00, 0, 2'b00, 0, NOP, 0, 0, 2'b00, 1);
`ifdef ACC_CU_TRAP_ILLEGAL_EN
        illegalNext = 2'b11;
`else
        illegalNext = 2'b00;
`endif

        rst = 1'b0; proc_en = 1'b0; scan_enable = 1'b0; scan_in = 1'b0;
        instr = 8'h00; ZF = 1'b0;
        tick(); tick(); #1;
        checkOutput("reset_ctrl", ctrl, ctrlOff);
        checkOutput("reset_state", 16'(dut.state_q), 16'h0000);

        // Release into STA and pull reset in the middle of its EXECUTE.
        rst = 1'b1; proc_en = 1'b1;
        applyStimulus(8'h27, 1'b0);
        checkOutput("first_fetch", ctrl, ctrlFetch);
        tick(); #1;
        checkOutput("sta_decode", ctrl, ctrlDecMem);
        tick(); #1;
        checkOutput("sta_exec", ctrl, mk(0, 2'b00, 0, 2'b00, 0, NOP, 0, 1, 2'b01, 0));
        rst = 1'b0; #1;
        checkOutput("midreset_ctrl", ctrl, ctrlOff);
        checkOutput("midreset_state", 16'(dut.state_q), 16'h0000);
        rst = 1'b1; #1;

        runInstr("lda05", 8'h05, 1'b0, ctrlDecMem,
                 mk(0, 2'b00, 1, 2'b01, 0, NOP, 0, 0, 2'b01, 0), 2'b00);
        runInstr("add46", 8'h46, 1'b0, ctrlDecMem,
                 mk(0, 2'b00, 1, 2'b00, 0, 4'b0000, 0, 0, 2'b01, 0), 2'b00);
        runInstr("sta27", 8'h27, 1'b0, ctrlDecMem,
                 mk(0, 2'b00, 0, 2'b00, 0, NOP, 0, 1, 2'b01, 0), 2'b00);
        runInstr("sub66", 8'h66, 1'b0, ctrlDecMem,
                 mk(0, 2'b00, 1, 2'b00, 0, 4'b0001, 0, 0, 2'b01, 0), 2'b00);
        runInstr("jz_taken", 8'hA9, 1'b1, ctrlOff,
                 mk(1, 2'b01, 0, 2'b00, 0, NOP, 0, 0, 2'b00, 0), 2'b00);
        runInstr("jz_not", 8'hA9, 1'b0, ctrlOff, ctrlOff, 2'b00);
        runInstr("jmp", 8'h83, 1'b0, ctrlOff,
                 mk(1, 2'b01, 0, 2'b00, 0, NOP, 0, 0, 2'b00, 0), 2'b00);
        runInstr("addi", 8'hC3, 1'b0, ctrlOff,
                 mk(0, 2'b00, 1, 2'b00, 0, 4'b0000, 1, 0, 2'b00, 0), 2'b00);
        runInstr("subi", 8'hD3, 1'b0, ctrlOff,
                 mk(0, 2'b00, 1, 2'b00, 0, 4'b0001, 1, 0, 2'b00, 0), 2'b00);
        runInstr("not", 8'hE0, 1'b0, ctrlOff,
                 mk(0, 2'b00, 1, 2'b00, 0, 4'b0101, 0, 0, 2'b00, 0), 2'b00);
        runInstr("clr", 8'hE1, 1'b0, ctrlOff,
                 mk(0, 2'b00, 1, 2'b10, 0, NOP, 0, 0, 2'b00, 0), 2'b00);

        // Freeze in DECODE, then resume into EXECUTE.
        applyStimulus(8'h05, 1'b0);
        tick();
        proc_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("freeze_ctrl", ctrl, ctrlOff);
            checkOutput("freeze_state", 16'(dut.state_q), 16'h0001);
            tick();
        end
        proc_en = 1'b1; #1;
        checkOutput("resume_decode", ctrl, ctrlDecMem);
        tick(); #1;
        checkOutput("resume_state", 16'(dut.state_q), 16'h0002);
        checkOutput("resume_exec", ctrl, mk(0, 2'b00, 1, 2'b01, 0, NOP, 0, 0, 2'b01, 0));
        tick(); #1;

        runInstr("illegal_e5", 8'hE5, 1'b0, ctrlOff, ctrlOff, illegalNext);
        rst = 1'b0; #1;
        rst = 1'b1; #1;

        runInstr("hlt", 8'hFF, 1'b0, ctrlOff, ctrlOff, 2'b11);
        for (int i = 0; i < 20; i++) begin
            checkOutput("halt_hold", ctrl, ctrlHalt);
            tick(); #1;
        end
        rst = 1'b0; #1;
        checkOutput("halt_reset", ctrl, ctrlOff);
        rst = 1'b1; #1;

        // Scan from DECODE (01): out shows state[0]=1, then old state[1]=0.
        applyStimulus(8'h05, 1'b0);
        tick();
        scan_enable = 1'b1; scan_in = 1'b1; #1;
        checkOutput("scan_out0", 16'(scan_out), 16'h0001);
        checkOutput("scan_gate", ctrl, ctrlOff);
        tick(); #1;
        checkOutput("scan_state1", 16'(dut.state_q), 16'h0002);
        checkOutput("scan_out1", 16'(scan_out), 16'h0000);
        tick(); #1;
        checkOutput("scan_state2", 16'(dut.state_q), 16'h0003);
        checkOutput("scan_halt", ctrl, ctrlHalt);
        scan_enable = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/accumulator_control_unit.md
Name: accumulator_control_unit

Overview:
- Multi-cycle FSM sequencer for the 8-bit accumulator microcontroller; drives every cu_* control net consumed by the PC, ACC, IR, memory and ALU datapath.
- Decodes the IR byte, samples ZF, steps FETCH -> DECODE -> EXECUTE, and parks in HALT on HLT.
- Its 2-bit state register is one segment of the design scan chain.

Parameters:
- STATE_W, 2, width of the scan-visible state register (fixed; kept only for scan-chain bookkeeping)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- proc_en  in  1  run enable; low freezes the sequencer
- scan_enable  in  1  scan shift mode
- scan_in  in  1  scan data in
- scan_out  out  1  scan data out, = state[0]
- instr  in  8  IR contents (ir_data_out)
- ZF  in  1  accumulator == 0, from datapath
- PC_write_enable  out  1  load PC
- PC_mux_select  out  2  00 PC+1, 01 instr[4:0], others reserved
- ACC_write_enable  out  1  load ACC
- ACC_mux_select  out  2  00 ALU Y, 01 memory data, 10 8'h00
- IR_load_enable  out  1  load IR from memory data
- ALU_opcode  out  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOT 0101, NOP 1111
- ALU_inputB_mux_select  out  1  0 memory data, 1 zero-extended instr[3:0]
- Memory_write_enable  out  1  write ACC to memory
- Memory_address_mux_select  out  2  00 PC, 01 instr[4:0]
- halt  out  1  high in HALT

Behaviour:
- States: FETCH=00, DECODE=01, EXECUTE=10, HALT=11. Reset -> FETCH.
- Transitions: FETCH->DECODE->EXECUTE->FETCH; EXECUTE of HLT -> HALT; HALT holds until reset.
- Moore/Mealy combinational outputs from state and instr. While rst low, scan_enable high, or proc_en low: all write/load enables = 0, ALU_opcode = NOP, mux selects = 00. halt reflects state (HALT) regardless.
- State advances only when proc_en=1 and scan_enable=0.
- FETCH: Memory_address_mux_select=00, IR_load_enable=1, PC_write_enable=1, PC_mux_select=00.
- DECODE: Memory_address_mux_select=01 for memory-operand instructions; memory read data is valid in EXECUTE; no writes.
- EXECUTE, by instr:
  - 000aaaaa LDA: ACC <- M[a] (ACC_mux 01).
  - 001aaaaa STA: Memory_write_enable=1, address mux 01.
  - 010aaaaa ADD: ALU ADD, B=mem, ACC_mux 00.
  - 011aaaaa SUB: ALU SUB, B=mem, ACC_mux 00.
  - 100aaaaa JMP: PC_write_enable=1, PC_mux 01.
  - 101aaaaa JZ: as JMP only if ZF=1, sampled in EXECUTE; otherwise no writes.
  - 1100iiii ADDI and 1101iiii SUBI: B mux 1, ACC write.
  - 11100000 NOT: ALU NOT. 11100001 CLR: ACC_mux 10.
  - 11111111 HLT.
  - All other encodings: NOP, no writes.
- Timing: 3 cycles per instruction; a taken jump overrides the PC+1 written in FETCH.
- Scan: when scan_enable=1, state <= {scan_in, state[1]} each clk. Shifted-in illegal values are impossible because all 4 codes are legal.
- Reset mid-instruction: returns to FETCH immediately; enables drop asynchronously.

Optional Feature:
- Macro ACC_CU_TRAP_ILLEGAL_EN.
- Defined: an undefined encoding in EXECUTE behaves as HLT (-> HALT, halt=1).
- Undefined: an undefined encoding executes as NOP and returns to FETCH.

Decomposition:
- Package acc_cu_pkg holds:
  - state enum
  - instruction class/opcode constants
  - ALU opcode localparams
  - PC, ACC and memory-address mux-select constants
- One natural sub-module, acc_cu_decoder: purely combinational mapping of state, instr and ZF to control outputs. The top keeps the state register, scan shift and enable gating.

Test Plan:
- Reset and fetch:
  - rst low mid-EXECUTE of STA -> Memory_write_enable drops in the same cycle; state=FETCH; halt=0.
  - Release with proc_en=1 -> IR_load_enable=1, PC_write_enable=1 on the first cycle.
- Instruction sequence: 0x05 (LDA 5), 0x46 (ADD 6), then 0x27 (STA 7).
  - Required outputs: EXECUTE pulses ACC_mux 01; then ALU 0000 with B mux 0; then Memory_write_enable=1 with address mux 01.
- JZ 0xA9:
  - ZF=1 -> PC_write_enable=1, PC_mux 01 in EXECUTE.
  - ZF=0 -> no PC write in EXECUTE.
- HLT 0xFF -> halt=1 from the cycle after EXECUTE; stays 1 for 20 cycles; all enables 0.
- proc_en low in DECODE for 5 cycles -> state frozen, enables 0; resumes into EXECUTE when proc_en goes high.
- Scan: scan_enable=1, shift in 1 then 1 -> state=HALT, halt=1; scan_out shows the old state bits in order state[0], state[1].
- With ACC_CU_TRAP_ILLEGAL_EN: 0xE5 -> HALT. Without it: 0xE5 -> NOP, back to FETCH.
